seg7_sequence_monitor: RTL and testbench

Reader side of the two-digit 7-segment display interface driven by main_counter. Samples the HEX0/HEX1 segment buses and decodes them back to BCD digits. Tracks the displayed count and flags any step that is not +1 modulo (MAX_COUNT+1). Used as an on-chip self-check beside main_counter and as a bench monitor.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_decode.sv | 29 ++
 rtl/seg7_sequence_monitor.sv | 168 ++++++++++++++++
 tb/tb_seg7_sequence_monitor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, types and helpers for the 7-segment monitor.
// Segment patterns are active-low, bit0=a .. bit6=g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    SYNC,
    TRACK,
    ERROR
  } state_t;

  typedef enum logic [1:0] {
    E_NONE    = 2'd0,
    E_ILLEGAL = 2'd1,
    E_STEP    = 2'd2,
    E_RANGE   = 2'd3
  } err_code_t;

  // Next two-digit BCD value, wrapping to 00 after max.
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: active-low 7-segment pattern back to a BCD digit.
// Ports: i_seg pattern in; o_legal high for 0-9 patterns; o_digit value.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_legal,
  output logic [3:0] o_digit
);

  always_comb begin
    o_legal = 1'b1;
    o_digit = 4'd0;
    unique case (i_seg)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_sequence_monitor.sv
// seg7_sequence_monitor: reads a two-digit 7-segment display, filters it,
// and checks that each accepted value is the previous one +1 (with wrap).
// Ports: CLK_50 clock; rst async active-low; HEX0/HEX1 ones/tens segments;
//   clr_err clears error and resyncs; value_bcd/value_valid tracked value;
//   step_pulse/step_count correct steps; err/err_code sticky error.
module seg7_sequence_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_COUNT     = 99,
  parameter int STEP_W        = 16
) (
  input  logic              CLK_50,
  input  logic              rst,
  input  logic [6:0]        HEX0,
  input  logic [6:0]        HEX1,
  input  logic              clr_err,
  output logic [7:0]        value_bcd,
  output logic              value_valid,
  output logic              step_pulse,
  output logic [STEP_W-1:0] step_count,
  output logic              err,
  output logic [1:0]        err_code
);

  // Counter runs one past the accept point and parks there, so each
  // stable run produces exactly one accept.
  localparam int CNT_W = $clog2(STABLE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES);
  localparam logic [7:0] MAX_BCD =
    {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};

  logic [13:0]       r_sync1;
  logic [13:0]       r_sync2;
  logic [CNT_W-1:0]  r_cnt;
  state_t            r_state;
  logic [7:0]        r_val;
  logic              r_valid;
  logic              r_pulse;
  logic [STEP_W-1:0] r_steps;
  logic              r_err;
  err_code_t         r_code;

  logic              w_change;
  logic              w_accept;
  logic              w_lo_ok;
  logic              w_hi_ok;
  logic [3:0]        w_lo;
  logic [3:0]        w_hi;
  logic              w_legal;
  logic [7:0]        w_word;
  logic              w_in_range;
  logic [7:0]        w_next;

  state_t            w_state_n;
  logic [7:0]        w_val_n;
  logic              w_valid_n;
  logic              w_pulse_n;
  logic [STEP_W-1:0] w_steps_n;
  logic              w_err_n;
  err_code_t         w_code_n;

  seg7_decode u_dec_lo (
    .i_seg   (r_sync2[6:0]),
    .o_legal (w_lo_ok),
    .o_digit (w_lo)
  );

  seg7_decode u_dec_hi (
    .i_seg   (r_sync2[13:7]),
    .o_legal (w_hi_ok),
    .o_digit (w_hi)
  );

  assign w_change   = (r_sync1 != r_sync2);
  assign w_accept   = (r_cnt == CNT_ACC);
  assign w_legal    = w_lo_ok & w_hi_ok;
  assign w_word     = {w_hi, w_lo};
  // BCD with legal digits orders the same as binary.
  assign w_in_range = (w_word <= MAX_BCD);
  assign w_next     = bcd_inc(r_val, MAX_BCD);

  always_ff @(posedge CLK_50 or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {HEX1, HEX0};
      r_sync2 <= r_sync1;
      if (w_change)
        r_cnt <= CNT_W'(1);
      else if (r_cnt <= CNT_ACC)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_val_n   = r_val;
    w_valid_n = r_valid;
    w_pulse_n = 1'b0;
    w_steps_n = r_steps;
    w_err_n   = r_err;
    w_code_n  = r_code;
    if (clr_err) begin
      w_state_n = SYNC;
      w_err_n   = 1'b0;
      w_code_n  = E_NONE;
    end else if (w_accept) begin
      if (r_state == ERROR) begin
        if (w_legal && w_in_range)
          w_val_n = w_word;
      end else if (!w_legal) begin
        w_state_n = ERROR;
        w_err_n   = 1'b1;
        w_code_n  = E_ILLEGAL;
      end else if (!w_in_range) begin
        w_state_n = ERROR;
        w_err_n   = 1'b1;
        w_code_n  = E_RANGE;
      end else if (r_state == SYNC) begin
        w_val_n   = w_word;
        w_valid_n = 1'b1;
        w_state_n = TRACK;
      end else if (w_word == w_next) begin
        w_val_n   = w_word;
        w_pulse_n = 1'b1;
        if (r_steps != '1)
          w_steps_n = r_steps + 1'b1;
      end else if (w_word != r_val) begin
        // Keep the new word so tracking resumes from it after clr_err.
        w_val_n   = w_word;
        w_state_n = ERROR;
        w_err_n   = 1'b1;
        w_code_n  = E_STEP;
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge rst) begin
    if (!rst) begin
      r_state <= SYNC;
      r_val   <= '0;
      r_valid <= 1'b0;
      r_pulse <= 1'b0;
      r_steps <= '0;
      r_err   <= 1'b0;
      r_code  <= E_NONE;
    end else begin
      r_state <= w_state_n;
      r_val   <= w_val_n;
      r_valid <= w_valid_n;
      r_pulse <= w_pulse_n;
      r_steps <= w_steps_n;
      r_err   <= w_err_n;
      r_code  <= w_code_n;
    end
  end

  assign value_bcd   = r_val;
  assign value_valid = r_valid;
  assign step_pulse  = r_pulse;
  assign step_count  = r_steps;
  assign err         = r_err;
  assign err_code    = r_code;

endmodule

// File: tb/tb_seg7_sequence_monitor.sv
// tb_seg7_sequence_monitor: scoreboard bench for seg7_sequence_monitor.
// Two instances: MAX_COUNT=99/STEP_W=16 and MAX_COUNT=59/STEP_W=2.
module tb_seg7_sequence_monitor;

  typedef struct packed {
    logic [7:0]  v;
    logic        vv;
    logic        sp;
    logic [15:0] sc;
    logic        e;
    logic [1:0]  ec;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr0 = 1'b0;
  logic        clr1 = 1'b0;
  logic [6:0]  h0_0, h1_0, h0_1, h1_1;

  logic [7:0]  v0, v1;
  logic        vv0, vv1, sp0, sp1, e0, e1;
  logic [15:0] sc0;
  logic [1:0]  sc1;
  logic [1:0]  ec0, ec1;

  int checks = 0;
  int errors = 0;
  int pulses0 = 0;

  obs_t q0[$];
  obs_t q1[$];
  obs_t prev0 = '0;
  obs_t prev1 = '0;
  obs_t cur0, cur1;

  always #10 clk = ~clk;

  seg7_sequence_monitor #(
    .STABLE_CYCLES (4),
    .MAX_COUNT     (99),
    .STEP_W        (16)
  ) u_dut0 (
    .CLK_50      (clk),
    .rst         (rst_n),
    .HEX0        (h0_0),
    .HEX1        (h1_0),
    .clr_err     (clr0),
    .value_bcd   (v0),
    .value_valid (vv0),
    .step_pulse  (sp0),
    .step_count  (sc0),
    .err         (e0),
    .err_code    (ec0)
  );

  seg7_sequence_monitor #(
    .STABLE_CYCLES (4),
    .MAX_COUNT     (59),
    .STEP_W        (2)
  ) u_dut1 (
    .CLK_50      (clk),
    .rst         (rst_n),
    .HEX0        (h0_1),
    .HEX1        (h1_1),
    .clr_err     (clr1),
    .value_bcd   (v1),
    .value_valid (vv1),
    .step_pulse  (sp1),
    .step_count  (sc1),
    .err         (e1),
    .err_code    (ec1)
  );

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic obs_t mk(
    input logic [7:0] v, input logic vv, input logic sp,
    input logic [15:0] sc, input logic e, input logic [1:0] ec
  );
    return {v, vv, sp, sc, e, ec};
  endfunction

  function automatic logic moved(input obs_t a, input obs_t b);
    return {a.v, a.vv, a.sc, a.e, a.ec} != {b.v, b.vv, b.sc, b.e, b.ec};
  endfunction

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: each visible change of the output tuple pops one expectation.
  always @(negedge clk) begin
    cur0 = mk(v0, vv0, sp0, sc0, e0, ec0);
    cur1 = mk(v1, vv1, sp1, {14'd0, sc1}, e1, ec1);
    if (sp0) pulses0++;
    if (moved(cur0, prev0)) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected: got %h expected none", cur0);
      end else begin
        cmp("dut0_event", cur0, q0.pop_front());
      end
    end
    if (moved(cur1, prev1)) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected: got %h expected none", cur1);
      end else begin
        cmp("dut1_event", cur1, q1.pop_front());
      end
    end
    prev0 = cur0;
    prev1 = cur1;
  end

  task automatic drive(
    input int d, input logic [6:0] hi, input logic [6:0] lo, input int hold
  );
    @(posedge clk);
    #1;
    if (d == 0) begin
      h1_0 = hi;
      h0_0 = lo;
    end else begin
      h1_1 = hi;
      h0_1 = lo;
    end
    repeat (hold) @(posedge clk);
  endtask

  task automatic show(input int d, input int t, input int o, input int hold);
    drive(d, seg(t), seg(o), hold);
  endtask

  task automatic pulse_clr0();
    @(posedge clk);
    #1 clr0 = 1'b1;
    @(posedge clk);
    #1 clr0 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    h1_0 = seg(0); h0_0 = seg(0);
    h1_1 = seg(5); h0_1 = seg(8);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_dut0", mk(v0, vv0, sp0, sc0, e0, ec0), '0);
    cmp("reset_dut1", mk(v1, vv1, sp1, {14'd0, sc1}, e1, ec1), '0);
    q0.push_back(mk(8'h00, 1, 0, 0, 0, 0));
    q1.push_back(mk(8'h58, 1, 0, 0, 0, 0));
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    q0.push_back(mk(8'h01, 1, 1, 1, 0, 0)); show(0, 0, 1, 10);
    q0.push_back(mk(8'h02, 1, 1, 2, 0, 0)); show(0, 0, 2, 10);
    pulse_clr0();
    q0.push_back(mk(8'h98, 1, 0, 2, 0, 0)); show(0, 9, 8, 10);
    q0.push_back(mk(8'h99, 1, 1, 3, 0, 0)); show(0, 9, 9, 10);
    q0.push_back(mk(8'h00, 1, 1, 4, 0, 0)); show(0, 0, 0, 10);
    q0.push_back(mk(8'h01, 1, 1, 5, 0, 0)); show(0, 0, 1, 10);
    show(0, 0, 5, 2);
    show(0, 0, 1, 10);

    q1.push_back(mk(8'h59, 1, 1, 1, 0, 0)); show(1, 5, 9, 10);
    q1.push_back(mk(8'h00, 1, 1, 2, 0, 0)); show(1, 0, 0, 10);
    q1.push_back(mk(8'h01, 1, 1, 3, 0, 0)); show(1, 0, 1, 10);
    q1.push_back(mk(8'h02, 1, 1, 3, 0, 0)); show(1, 0, 2, 10);
    q1.push_back(mk(8'h02, 1, 0, 3, 1, 3)); show(1, 6, 0, 10);

    q0.push_back('0);
    q1.push_back('0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    h1_0 = seg(4); h0_0 = seg(2);
    h1_1 = seg(5); h0_1 = seg(8);
    #1;
    cmp("midrst_dut0", mk(v0, vv0, sp0, sc0, e0, ec0), '0);
    cmp("midrst_dut1", mk(v1, vv1, sp1, {14'd0, sc1}, e1, ec1), '0);
    repeat (3) @(posedge clk);
    q0.push_back(mk(8'h42, 1, 0, 0, 0, 0));
    q1.push_back(mk(8'h58, 1, 0, 0, 0, 0));
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    q0.push_back(mk(8'h43, 1, 1, 1, 0, 0)); show(0, 4, 3, 10);
    q0.push_back(mk(8'h05, 1, 0, 1, 1, 2)); show(0, 0, 5, 10);
    q0.push_back(mk(8'h07, 1, 0, 1, 1, 2)); show(0, 0, 7, 10);
    q0.push_back(mk(8'h07, 1, 0, 1, 0, 0)); pulse_clr0();
    q0.push_back(mk(8'h08, 1, 0, 1, 0, 0)); show(0, 0, 8, 10);
    q0.push_back(mk(8'h09, 1, 1, 2, 0, 0)); show(0, 0, 9, 10);
    q0.push_back(mk(8'h09, 1, 0, 2, 1, 1));
    drive(0, seg(0), 7'b1111111, 10);
    q0.push_back(mk(8'h09, 1, 0, 2, 0, 0)); pulse_clr0();
    q0.push_back(mk(8'h10, 1, 0, 2, 0, 0)); show(0, 1, 0, 10);

    // Wrong value 15 accepted in the same cycle clr_err is high.
    @(posedge clk);
    #1;
    h1_0 = seg(1); h0_0 = seg(5);
    repeat (5) @(posedge clk);
    #1 clr0 = 1'b1;
    @(posedge clk);
    #1 clr0 = 1'b0;
    repeat (6) @(posedge clk);
    q0.push_back(mk(8'h20, 1, 0, 2, 0, 0)); show(0, 2, 0, 10);

    repeat (5) @(posedge clk);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0_pending: got %0d expected 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1_pending: got %0d expected 0", q1.size());
    end
    checks++;
    if (pulses0 != 7) begin
      errors++;
      $display("FAIL dut0_pulses: got %0d expected 7", pulses0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
